// File: rtl/fft_sample_loader_pkg.sv
// ============================================================================
// Module      : fft_sample_loader_pkg
// Description : Shared FFT frame types, sizes and the index bit-reversal.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fft_sample_loader_pkg;

    localparam int D_WIDTH     = 64;
    localparam int LOG_2_WIDTH = 6;
    localparam int SAMPLE_W    = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    localparam logic [1:0] c_ST_FILL   = 2'd0;
    localparam logic [1:0] c_ST_LAUNCH = 2'd1;
    localparam logic [1:0] c_ST_HOLD   = 2'd2;

    typedef enum logic [1:0] {
        ST_FILL   = c_ST_FILL,
        ST_LAUNCH = c_ST_LAUNCH,
        ST_HOLD   = c_ST_HOLD
    } state_t;

    // Reverses the low 'width' bits of idx; bits above 'width' come back zero.
    function automatic logic [31:0] bitrev(input logic [31:0] idx, input int unsigned width);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < width) begin
                r[width-1-i] = idx[i];
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fft_sample_loader_regfile.sv
// ============================================================================
// Module      : frame_regfile
// Description : Indexed, write-enabled DEPTH x 32-bit register array with
//               synchronous clear, all entries visible in parallel.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_regfile
    import fft_sample_loader_pkg::*;
#(
    parameter int DEPTH  = D_WIDTH,
    parameter int ADDR_W = LOG_2_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_we,
    input  logic [ADDR_W-1:0]       i_addr,
    input  logic [31:0]             i_wdata,
    output logic [DEPTH-1:0][31:0]  o_mem
);

    logic [31:0] r_mem [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_elem
        always_ff @(posedge clk) begin
            if (rst) begin
                r_mem[i] <= '0;
            end else if (i_we && (i_addr == ADDR_W'(i))) begin
                r_mem[i] <= i_wdata;
            end
        end

        assign o_mem[i] = r_mem[i];
    end

endmodule

`default_nettype wire

// File: rtl/fft_sample_loader.sv
// ============================================================================
// Module      : fft_sample_loader
// Description : Collects a serial complex sample stream into a bit-reversed
//               parallel frame and hands it to the butterfly with a start pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_sample_loader
    import fft_sample_loader_pkg::*;
#(
    parameter int D_WIDTH     = fft_sample_loader_pkg::D_WIDTH,
    parameter int LOG_2_WIDTH = fft_sample_loader_pkg::LOG_2_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  sample_t                   in_re,
    input  sample_t                   in_im,
    input  logic                      in_last,
    input  logic                      fft_done,
    output sample_t [D_WIDTH-1:0]     frame_re,
    output sample_t [D_WIDTH-1:0]     frame_im,
    output logic                      start,
    output logic                      busy,
    output logic                      frame_err
);

    localparam logic [LOG_2_WIDTH-1:0] c_LAST_IDX = LOG_2_WIDTH'(D_WIDTH - 1);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [LOG_2_WIDTH-1:0]   r_wr_idx;
    logic [LOG_2_WIDTH-1:0]   w_wr_idx_nxt;
    logic                     r_frame_err;
    logic                     w_frame_err_nxt;
    logic                     w_accept;
    logic                     w_at_last;
    logic [LOG_2_WIDTH-1:0]   w_wr_addr;
    logic [31:0]              w_bitrev;
    logic [D_WIDTH-1:0][31:0] w_mem;

    assign w_at_last = (r_wr_idx == c_LAST_IDX);
    assign w_bitrev  = bitrev(32'(r_wr_idx), LOG_2_WIDTH);
    assign w_wr_addr = w_bitrev[LOG_2_WIDTH-1:0];
    assign frame_err = r_frame_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_FILL;
            r_wr_idx    <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wr_idx    <= w_wr_idx_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_wr_idx_nxt    = r_wr_idx;
        w_frame_err_nxt = 1'b0;
        w_accept        = 1'b0;
        in_ready        = 1'b0;
        start           = 1'b0;
        busy            = 1'b0;
        case (r_state)
            ST_FILL: begin
                in_ready = 1'b1;
                w_accept = in_valid;
                if (w_accept) begin
                    if (w_at_last) begin
                        // A full frame launches even if in_last was missing.
                        w_state_nxt     = ST_LAUNCH;
                        w_wr_idx_nxt    = '0;
                        w_frame_err_nxt = ~in_last;
                    end else if (in_last) begin
                        w_wr_idx_nxt    = '0;
                        w_frame_err_nxt = 1'b1;
                    end else begin
                        w_wr_idx_nxt    = r_wr_idx + 1'b1;
                    end
                end
            end
            ST_LAUNCH: begin
                start       = 1'b1;
                busy        = 1'b1;
                w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                busy = 1'b1;
                if (fft_done) begin
                    w_state_nxt = ST_FILL;
                end
            end
            default: begin
                w_state_nxt = ST_FILL;
            end
        endcase
    end

    frame_regfile #(
        .DEPTH  (D_WIDTH),
        .ADDR_W (LOG_2_WIDTH)
    ) u_frame_regfile (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_accept),
        .i_addr  (w_wr_addr),
        .i_wdata ({in_re, in_im}),
        .o_mem   (w_mem)
    );

    for (genvar i = 0; i < D_WIDTH; i++) begin : g_split
        assign frame_re[i] = w_mem[i][31:16];
        assign frame_im[i] = w_mem[i][15:0];
    end

endmodule

`default_nettype wire
